// File: rtl/texture_write_arbiter.sv
// Round-robin arbiter that serializes two AXI4-Lite write requesters onto one
// downstream write port, with one transaction outstanding at a time.
module texture_write_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s0_awaddr,
  input  logic [2:0]            s0_awprot,
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  output logic [1:0]            s0_bresp,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  input  logic [ADDR_WIDTH-1:0] s1_awaddr,
  input  logic [2:0]            s1_awprot,
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  output logic [1:0]            s1_bresp,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  addr_ok_q, addr_ok_d;
  logic                  data_ok_q, data_ok_d;
  logic                  aw_sent_q, aw_sent_d;
  logic                  w_sent_q, w_sent_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  s0_req, s1_req;
  logic                  sel_awvalid, sel_wvalid, sel_bready;
  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic [2:0]            sel_awprot;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign s0_req      = s0_awvalid | s0_wvalid;
  assign s1_req      = s1_awvalid | s1_wvalid;
  assign sel_awvalid = grant_q ? s1_awvalid : s0_awvalid;
  assign sel_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
  assign sel_bready  = grant_q ? s1_bready  : s0_bready;
  assign sel_awaddr  = grant_q ? s1_awaddr  : s0_awaddr;
  assign sel_awprot  = grant_q ? s1_awprot  : s0_awprot;
  assign sel_wdata   = grant_q ? s1_wdata   : s0_wdata;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_ok_d    = addr_ok_q;
    data_ok_d    = data_ok_q;
    aw_sent_d    = aw_sent_q;
    w_sent_d     = w_sent_q;
    addr_d       = addr_q;
    prot_d       = prot_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (s0_req || s1_req) begin
          grant_d = (s0_req && s1_req) ? !last_grant_q : s1_req;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (sel_awvalid && !addr_ok_q) begin
          addr_ok_d = 1'b1;
          addr_d    = sel_awaddr;
          prot_d    = sel_awprot;
        end
        if (sel_wvalid && !data_ok_q) begin
          data_ok_d = 1'b1;
          data_d    = sel_wdata;
        end
        if (addr_ok_d && data_ok_d) state_d = ISSUE;
      end
      ISSUE: begin
        if (m_awready && !aw_sent_q) aw_sent_d = 1'b1;
        if (m_wready && !w_sent_q)   w_sent_d  = 1'b1;
        if (aw_sent_d && w_sent_d)   state_d   = RESP;
      end
      RESP: begin
        if (m_bvalid && sel_bready) begin
          last_grant_d = grant_q;
          addr_ok_d    = 1'b0;
          data_ok_d    = 1'b0;
          aw_sent_d    = 1'b0;
          w_sent_d     = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      aw_sent_q    <= 1'b0;
      w_sent_q     <= 1'b0;
      addr_q       <= '0;
      prot_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_ok_q    <= addr_ok_d;
      data_ok_q    <= data_ok_d;
      aw_sent_q    <= aw_sent_d;
      w_sent_q     <= w_sent_d;
      addr_q       <= addr_d;
      prot_q       <= prot_d;
      data_q       <= data_d;
    end
  end

  // Handshake signals decode from registered state; only the B channel is a
  // combinational pass-through to the granted port.
  assign s0_awready = (state_q == COLLECT) && !grant_q && !addr_ok_q;
  assign s1_awready = (state_q == COLLECT) &&  grant_q && !addr_ok_q;
  assign s0_wready  = (state_q == COLLECT) && !grant_q && !data_ok_q;
  assign s1_wready  = (state_q == COLLECT) &&  grant_q && !data_ok_q;
  assign s0_bvalid  = (state_q == RESP) && !grant_q && m_bvalid;
  assign s1_bvalid  = (state_q == RESP) &&  grant_q && m_bvalid;
  assign s0_bresp   = ((state_q == RESP) && !grant_q) ? m_bresp : 2'b00;
  assign s1_bresp   = ((state_q == RESP) &&  grant_q) ? m_bresp : 2'b00;
  assign m_awvalid  = (state_q == ISSUE) && !aw_sent_q;
  assign m_wvalid   = (state_q == ISSUE) && !w_sent_q;
  assign m_bready   = (state_q == RESP) && sel_bready;
  assign m_awaddr   = addr_q;
  assign m_awprot   = prot_q;
  assign m_wdata    = data_q;

endmodule
